// File: rtl/switch_cfg_loader.sv
// Loads framed route words into a shadow store and commits them atomically to the switch matrix.
// Define CFG_CHECK_EN to require a trailing XOR checksum word per frame.
module switch_cfg_loader #(
  parameter int          NTOP  = 5,
  parameter int          NSIDE = 4,
  parameter logic [5:0]  SYNC  = 6'h2A
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [5:0]           s_data,
  output logic                 s_ready,
  output logic [6*NTOP-1:0]    cfg_top,
  output logic [6*NTOP-1:0]    cfg_bottom,
  output logic [6*NSIDE-1:0]   cfg_left,
  output logic [6*NSIDE-1:0]   cfg_right,
  output logic                 cfg_update,
  output logic                 frame_err,
  output logic                 cfg_valid
);

  localparam int             NW   = 2*NTOP + 2*NSIDE;
  localparam int             CW   = $clog2(NW);
  localparam logic [CW-1:0]  LAST = CW'(NW-1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef CFG_CHECK_EN
    CHECK,
`endif
    COMMIT,
    ERR
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [5:0]     r_shadow [NW];
  logic [5:0]     r_cfg    [NW];
  logic           r_cfg_valid;
  logic           w_xfer;
  logic           w_legal;
  logic           w_load;
  logic           w_sync;

  // side 0 is undriven; top/bottom sources index the NTOP edge, left/right the NSIDE edge
  function automatic logic f_legal(input logic [5:0] w);
    logic ok;
    case (w[2:0])
      3'd0:       ok = 1'b1;
      3'd1, 3'd3: ok = (int'(w[5:3]) < NTOP);
      3'd2, 3'd4: ok = (int'(w[5:3]) < NSIDE);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_xfer  = s_valid && s_ready;
  assign w_legal = f_legal(s_data);
  assign w_load  = (r_state == LOAD) && w_xfer && w_legal;
  assign w_sync  = (r_state == IDLE) && w_xfer && (s_data == SYNC);

  always_comb begin
    w_next     = r_state;
    s_ready    = 1'b0;
    cfg_update = 1'b0;
    frame_err  = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        if (w_sync) w_next = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (w_xfer) begin
          if (!w_legal) begin
            w_next = ERR;
          end else if (r_cnt == LAST) begin
`ifdef CFG_CHECK_EN
            w_next = CHECK;
`else
            w_next = COMMIT;
`endif
          end
        end
      end
`ifdef CFG_CHECK_EN
      CHECK: begin
        s_ready = 1'b1;
        if (w_xfer) w_next = (s_data == r_csum) ? COMMIT : ERR;
      end
`endif
      COMMIT: begin
        cfg_update = 1'b1;
        w_next     = IDLE;
      end
      ERR: begin
        frame_err = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cfg_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_sync) r_cnt <= '0;
      else if (w_load) r_cnt <= r_cnt + CW'(1);
      if (r_state == COMMIT) r_cfg_valid <= 1'b1;
      else if (r_state == ERR) r_cfg_valid <= 1'b0;
    end
  end

`ifdef CFG_CHECK_EN
  logic [5:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_sync) begin
      r_csum <= '0;
    end else if (w_load) begin
      r_csum <= r_csum ^ s_data;
    end
  end
`endif

  // shadow fills word by word; the live config only moves on the commit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        r_shadow[k] <= '0;
        r_cfg[k]    <= '0;
      end
    end else begin
      if (w_load) r_shadow[r_cnt] <= s_data;
      if (r_state == COMMIT) begin
        for (int k = 0; k < NW; k++) r_cfg[k] <= r_shadow[k];
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NTOP; gi++) begin : g_tb
    assign cfg_top[6*gi +: 6]    = r_cfg[gi];
    assign cfg_bottom[6*gi +: 6] = r_cfg[NTOP + gi];
  end
  for (gi = 0; gi < NSIDE; gi++) begin : g_lr
    assign cfg_left[6*gi +: 6]  = r_cfg[2*NTOP + gi];
    assign cfg_right[6*gi +: 6] = r_cfg[2*NTOP + NSIDE + gi];
  end

  assign cfg_valid = r_cfg_valid;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Bench for switch_cfg_loader: legality vector table, reset/checksum sequences and random framed traffic.
module tb_switch_cfg_loader;

  localparam int         NTOP  = 5;
  localparam int         NSIDE = 4;
  localparam int         NW    = 2*NTOP + 2*NSIDE;
  localparam logic [5:0] SYNC  = 6'h2A;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic [5:0]           s_data = '0;
  logic                 s_ready;
  logic [6*NTOP-1:0]    cfg_top;
  logic [6*NTOP-1:0]    cfg_bottom;
  logic [6*NSIDE-1:0]   cfg_left;
  logic [6*NSIDE-1:0]   cfg_right;
  logic                 cfg_update;
  logic                 frame_err;
  logic                 cfg_valid;

  switch_cfg_loader #(.NTOP(NTOP), .NSIDE(NSIDE), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_top(cfg_top), .cfg_bottom(cfg_bottom), .cfg_left(cfg_left), .cfg_right(cfg_right),
    .cfg_update(cfg_update), .frame_err(frame_err), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] frm     [NW];
  logic [5:0] exp_cfg [NW];
  bit         exp_valid = 1'b0;

  typedef struct {
    int         pos;
    logic [5:0] word;
    bit         legal;
  } vec_t;
  vec_t vt [12];

  // reference legality: side 0 free, 1/3 index < NTOP, 2/4 index < NSIDE, 5..7 never
  function automatic bit legal(input logic [5:0] w);
    int side;
    int idx;
    side = int'(w[2:0]);
    idx  = int'(w[5:3]);
    if (side == 0) return 1'b1;
    if (side == 1 || side == 3) return idx < NTOP;
    if (side == 2 || side == 4) return idx < NSIDE;
    return 1'b0;
  endfunction

  function automatic logic [5:0] rand_legal();
    int side;
    int idx;
    side = int'($urandom_range(4));
    if (side == 0) idx = int'($urandom_range(7));
    else if (side == 1 || side == 3) idx = int'($urandom_range(NTOP-1));
    else idx = int'($urandom_range(NSIDE-1));
    return {3'(idx), 3'(side)};
  endfunction

  function automatic logic [5:0] rand_illegal();
    int k;
    k = int'($urandom_range(2));
    if (k == 0) return {3'($urandom_range(7)), 3'($urandom_range(7, 5))};
    if (k == 1) return {3'($urandom_range(7, NTOP)), ($urandom_range(1) != 0) ? 3'd1 : 3'd3};
    return {3'($urandom_range(7, NSIDE)), ($urandom_range(1) != 0) ? 3'd2 : 3'd4};
  endfunction

  function automatic logic [5:0] frame_xor();
    logic [5:0] x;
    x = '0;
    foreach (frm[i]) x = x ^ frm[i];
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_cfg(input string nm);
    logic [6*NTOP-1:0]  t;
    logic [6*NTOP-1:0]  b;
    logic [6*NSIDE-1:0] l;
    logic [6*NSIDE-1:0] r;
    for (int i = 0; i < NTOP; i++) begin
      t[6*i +: 6] = exp_cfg[i];
      b[6*i +: 6] = exp_cfg[NTOP + i];
    end
    for (int j = 0; j < NSIDE; j++) begin
      l[6*j +: 6] = exp_cfg[2*NTOP + j];
      r[6*j +: 6] = exp_cfg[2*NTOP + NSIDE + j];
    end
    chk({nm, "_top"}, 32'(cfg_top), 32'(t));
    chk({nm, "_bottom"}, 32'(cfg_bottom), 32'(b));
    chk({nm, "_left"}, 32'(cfg_left), 32'(l));
    chk({nm, "_right"}, 32'(cfg_right), 32'(r));
  endtask

  task automatic check_quiet(input string nm);
    chk_cfg(nm);
    chk({nm, "_valid"}, 32'(cfg_valid), 32'(exp_valid));
    chk({nm, "_update"}, 32'(cfg_update), 32'd0);
    chk({nm, "_err"}, 32'(frame_err), 32'd0);
    chk({nm, "_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic err_pulse(input string nm);
    chk({nm, "_errpulse"}, 32'(frame_err), 32'd1);
    chk({nm, "_noupd"}, 32'(cfg_update), 32'd0);
    chk({nm, "_busy"}, 32'(s_ready), 32'd0);
    chk_cfg({nm, "_keep"});
    @(posedge clk); #1;
    exp_valid = 1'b0;
    chk({nm, "_validlow"}, 32'(cfg_valid), 32'd0);
    chk({nm, "_errdone"}, 32'(frame_err), 32'd0);
    chk({nm, "_readyback"}, 32'(s_ready), 32'd1);
    chk_cfg({nm, "_kept"});
  endtask

  task automatic commit_pulse(input string nm);
    chk({nm, "_updpulse"}, 32'(cfg_update), 32'd1);
    chk({nm, "_busy"}, 32'(s_ready), 32'd0);
    chk_cfg({nm, "_precommit"});
    @(posedge clk); #1;
    foreach (frm[i]) exp_cfg[i] = frm[i];
    exp_valid = 1'b1;
    chk({nm, "_validhigh"}, 32'(cfg_valid), 32'd1);
    chk({nm, "_upddone"}, 32'(cfg_update), 32'd0);
    chk({nm, "_readyback"}, 32'(s_ready), 32'd1);
    chk_cfg({nm, "_committed"});
  endtask

  // present one word, optionally after random idle cycles, and wait (bounded) for the transfer
  task automatic send(input logic [5:0] w, input int gap_pct);
    int g;
    g = 0;
    @(negedge clk);
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct && g < 4) begin
      s_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    s_valid = 1'b1;
    s_data  = w;
    g = 0;
    while (!s_ready && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: s_ready got 0, required 1 (t=%0t)", $time);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 6'($urandom);
  endtask

  task automatic send_frame(input int gap_pct, input bit flip, input bit extra);
    int         bad;
    logic [5:0] cs;
    bad = -1;
    for (int i = 0; i < NW; i++) if (bad < 0 && !legal(frm[i])) bad = i;
    cs = frame_xor() ^ (flip ? 6'd1 : 6'd0);
    send(SYNC, gap_pct);
    check_quiet("sync");
    for (int i = 0; i < NW; i++) begin
      send(frm[i], gap_pct);
      if (i == bad) begin
        err_pulse("route");
      end else if (bad < 0 && i == NW-1) begin
`ifdef CFG_CHECK_EN
        check_quiet("lastword");
        send(cs, gap_pct);
        if (flip) err_pulse("csum");
        else commit_pulse("csum");
`else
        commit_pulse("frame");
        if (extra && cs != SYNC) begin
          send(cs, gap_pct);
          check_quiet("extra");
        end
`endif
      end else begin
        check_quiet("mid");
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (exp_cfg[i]) exp_cfg[i] = '0;
    exp_valid = 1'b0;
    check_quiet("reset");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{0,  6'b001_010, 1'b1};
    vt[1]  = '{3,  6'b000_101, 1'b0};
    vt[2]  = '{10, 6'b101_001, 1'b0};
    vt[3]  = '{10, 6'b100_001, 1'b1};
    vt[4]  = '{5,  6'h2A,      1'b0};
    vt[5]  = '{17, 6'b011_100, 1'b1};
    vt[6]  = '{17, 6'b100_100, 1'b0};
    vt[7]  = '{2,  6'b111_000, 1'b1};
    vt[8]  = '{8,  6'b100_011, 1'b1};
    vt[9]  = '{12, 6'b000_111, 1'b0};
    vt[10] = '{14, 6'b010_110, 1'b0};
    vt[11] = '{1,  6'b011_010, 1'b1};

    foreach (exp_cfg[i]) exp_cfg[i] = '0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int v = 0; v < 12; v++) begin
      foreach (frm[i]) frm[i] = '0;
      frm[vt[v].pos] = vt[v].word;
      send_frame(0, 1'b0, 1'b0);
      chk("vec_valid", 32'(cfg_valid), 32'(vt[v].legal));
    end

    foreach (frm[i]) frm[i] = rand_legal();
    send_frame(0, 1'b0, 1'b0);
    foreach (frm[i]) frm[i] = rand_legal();
    send_frame(0, 1'b1, 1'b1);

    send(SYNC, 0);
    check_quiet("rst_sync");
    for (int i = 0; i < 7; i++) begin
      send(rand_legal(), 0);
      check_quiet("rst_mid");
    end
    do_reset();
    foreach (frm[i]) frm[i] = rand_legal();
    send_frame(0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      foreach (frm[i]) frm[i] = rand_legal();
      if ($urandom_range(99) < 30) frm[$urandom_range(NW-1)] = rand_illegal();
      send_frame((n % 2 == 0) ? 50 : 0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
